// File: rtl/vec_div_scalar.sv
// -----------------------------------------------------------------------------
// vec_div_scalar
//   Sequential Q16.16 vector-by-scalar divider: out_i = (x_i << FRAC) / a for
//   i = 0..2. A single restoring divider works through the three components in
//   turn. The handshake is valid/ready on both the input and the output side.
//   The latency is fixed at 3*(W+FRAC+2) cycles from the accept edge to
//   out_valid, whatever the data.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any divide in flight)
//   x0,x1,x2     signed dividend vector, Q16.16
//   a            signed divisor, Q16.16
//   in_valid     input vector/divisor valid
//   in_ready     block idle, accepts input
//   out0..out2   signed quotient vector, Q16.16
//   out_valid    results valid, held until out_ready
//   out_ready    downstream accepts results
//   div0         divisor was zero for this result
//   sat          at least one component saturated
// -----------------------------------------------------------------------------
module vec_div_scalar #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] a,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         div0,
    output logic         sat
);
    localparam int DW = W + FRAC;
    localparam int CW = $clog2(DW);

    localparam logic [W-1:0]  MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
    // Largest quotient magnitudes that still fit each sign of the result.
    localparam logic [DW-1:0] Q_POS_LIM = {{(FRAC+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [DW-1:0] Q_NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIX, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_x0, r_x1, r_x2, r_a;
    logic [1:0]      r_idx;
    logic [DW-1:0]   r_dvd;      // dividend in, quotient shifted in from the LSB
    logic [W-1:0]    r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_sat_acc;

    logic [W-1:0]    w_xi, w_mag_x, w_mag_a, w_res;
    logic [W:0]      w_rem_sh;
    logic            w_ge, w_neg, w_sat_c;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    // Select the component currently being divided.
    always_comb begin
        w_xi = r_x0;
        case (r_idx)
            2'd1:    w_xi = r_x1;
            2'd2:    w_xi = r_x2;
            default: w_xi = r_x0;
        endcase
    end

    // Magnitudes as unsigned W bits; -2^(W-1) maps to 2^(W-1), which still fits.
    assign w_mag_x = w_xi[W-1] ? (~w_xi + 1'b1) : w_xi;
    assign w_mag_a = r_a[W-1]  ? (~r_a  + 1'b1) : r_a;

    // One restoring step. The remainder stays below |a| <= 2^(W-1), so the
    // subtraction result always fits in W bits when it is taken.
    assign w_rem_sh = {r_rem, r_dvd[DW-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, w_mag_a});

    assign w_neg = w_xi[W-1] ^ r_a[W-1];

    // Sign fix-up and saturation of the finished quotient (r_dvd).
    always_comb begin
        w_res   = '0;
        w_sat_c = 1'b0;
        if (r_a == '0) begin
            if (w_xi == '0)     w_res = '0;
            else if (w_xi[W-1]) w_res = MIN_NEG;
            else                w_res = MAX_POS;
        end else if (!w_neg) begin
            if (r_dvd > Q_POS_LIM) begin
                w_res   = MAX_POS;
                w_sat_c = 1'b1;
            end else begin
                w_res = r_dvd[W-1:0];
            end
        end else begin
            if (r_dvd > Q_NEG_LIM) begin
                w_res   = MIN_NEG;
                w_sat_c = 1'b1;
            end else begin
                w_res = ~r_dvd[W-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_SETUP;
            S_SETUP: w_next = S_ITER;
            S_ITER:  if (r_cnt == CW'(DW-1)) w_next = S_FIX;
            S_FIX:   w_next = (r_idx == 2'd2) ? S_DONE : S_SETUP;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_a       <= '0;
            r_idx     <= '0;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sat_acc <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            div0      <= 1'b0;
            sat       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x0      <= x0;
                        r_x1      <= x1;
                        r_x2      <= x2;
                        r_a       <= a;
                        r_idx     <= '0;
                        r_sat_acc <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_dvd <= {w_mag_x, {FRAC{1'b0}}};
                    r_rem <= '0;
                    r_cnt <= '0;
                end
                S_ITER: begin
                    r_dvd <= {r_dvd[DW-2:0], w_ge};
                    r_rem <= w_ge ? (w_rem_sh[W-1:0] - w_mag_a) : w_rem_sh[W-1:0];
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    case (r_idx)
                        2'd0:    out0 <= w_res;
                        2'd1:    out1 <= w_res;
                        default: out2 <= w_res;
                    endcase
                    r_sat_acc <= r_sat_acc | w_sat_c;
                    r_idx     <= r_idx + 1'b1;
                    // Flags are published only as the vector completes.
                    if (r_idx == 2'd2) begin
                        div0 <= (r_a == '0);
                        sat  <= r_sat_acc | w_sat_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_div_scalar.sv
module tb_vec_div_scalar;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x0, x1, x2, a;
    logic        in_valid, in_ready;
    logic [31:0] out0, out1, out2;
    logic        out_valid, out_ready, div0, sat;

    always #5 clk = ~clk;

    vec_div_scalar #(.W(32), .FRAC(16)) dut (
        .clk(clk), .rst(rst), .x0(x0), .x1(x1), .x2(x2), .a(a),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0(out0), .out1(out1), .out2(out2),
        .out_valid(out_valid), .out_ready(out_ready), .div0(div0), .sat(sat)
    );

    typedef struct packed {
        logic [31:0] o0, o1, o2;
        logic        d0, st;
    } res_t;

    res_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference for one component: {sat, value}.
    function automatic logic [32:0] comp(input logic [31:0] x, input logic [31:0] d);
        longint xs, ds, mx, md, q;
        logic [31:0] v;
        if (d == 32'h0) begin
            if (x == 32'h0) return 33'h0;
            return x[31] ? {1'b0, 32'h80000000} : {1'b0, 32'h7FFFFFFF};
        end
        xs = longint'($signed(x));
        ds = longint'($signed(d));
        mx = (xs < 0) ? -xs : xs;
        md = (ds < 0) ? -ds : ds;
        q  = (mx <<< 16) / md;
        if (x[31] == d[31]) begin
            if (q > 64'sh7FFFFFFF) return {1'b1, 32'h7FFFFFFF};
            v = q[31:0];
            return {1'b0, v};
        end
        if (q > 64'sh80000000) return {1'b1, 32'h80000000};
        q = -q;
        v = q[31:0];
        return {1'b0, v};
    endfunction

    function automatic res_t model(input logic [31:0] m0, m1, m2, d);
        logic [32:0] c0, c1, c2;
        res_t r;
        c0 = comp(m0, d);
        c1 = comp(m1, d);
        c2 = comp(m2, d);
        r.o0 = c0[31:0];
        r.o1 = c1[31:0];
        r.o2 = c2[31:0];
        r.d0 = (d == 32'h0);
        r.st = c0[32] | c1[32] | c2[32];
        return r;
    endfunction

    // Offer a vector and return just after its accept edge.
    task automatic drive(input logic [31:0] v0, v1, v2, d, input bit push);
        int w = 0;
        while (!in_ready && w < 300) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL drive_timeout: in_ready=%0b required 1", in_ready);
        end
        x0 = v0; x1 = v1; x2 = v2; a = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back(model(v0, v1, v2, d));
    endtask

    task automatic wait_out(output int lat, output res_t got);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        got = {out0, out1, out2, div0, sat};
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_total++;
        if ({out0, out1, out2, div0, sat, out_valid} !== 99'h0) begin
            $display("FAIL reset_outputs: got %h %h %h d0=%0b sat=%0b ov=%0b required all 0",
                     out0, out1, out2, div0, sat, out_valid);
        end else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        else n_pass++;
    endtask

    // Shared body for the fixed vectors: DUT vs scoreboard, vs literal, latency.
    task automatic test_table(input string name, input logic [31:0] v0, v1, v2, d, input res_t lit);
        int   lat;
        res_t got, exp;
        drive(v0, v1, v2, d, 1'b1);
        wait_out(lat, got);
        exp = sb.pop_front();
        n_total++;
        if (got !== exp) $display("FAIL %s_sb: got %h required %h", name, got, exp);
        else n_pass++;
        n_total++;
        if (got !== lit) $display("FAIL %s_lit: got %h required %h", name, got, lit);
        else n_pass++;
        n_total++;
        if (lat !== 150) $display("FAIL %s_latency: got %0d required 150", name, lat);
        else n_pass++;
        release_out();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL %s_release: in_ready=%0b out_valid=%0b required 1/0", name, in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        test_table("basic_halves", 32'h00030000, 32'hFFFE8000, 32'h00004000, 32'h00020000,
                   {32'h00018000, 32'hFFFF4000, 32'h00002000, 1'b0, 1'b0});
        test_table("basic_thirds", 32'h00010000, 32'hFFFF0000, 32'h0, 32'h00030000,
                   {32'h00005555, 32'hFFFFAAAB, 32'h0, 1'b0, 1'b0});
    endtask

    task automatic test_div0();
        test_table("div0", 32'h00050000, 32'hFFFB0000, 32'h0, 32'h0,
                   {32'h7FFFFFFF, 32'h80000000, 32'h0, 1'b1, 1'b0});
    endtask

    task automatic test_saturate();
        test_table("sat_neg1", 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFF0000,
                   {32'h80000001, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1});
        test_table("sat_small", 32'h7FFFFFFF, 32'h0, 32'h0, 32'h00000100,
                   {32'h7FFFFFFF, 32'h0, 32'h0, 1'b0, 1'b1});
    endtask

    task automatic test_hold();
        int   lat;
        res_t got, exp, now;
        drive(32'h00070000, 32'hFFF90000, 32'h00000001, 32'hFFFE0000, 1'b1);
        wait_out(lat, got);
        x0 = 32'h11111111; x1 = 32'h22222222; x2 = 32'h33333333; a = 32'h00010000;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            now = {out0, out1, out2, div0, sat};
            n_total++;
            if (now !== got || in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL hold_stable: cyc %0d got %h ir=%0b ov=%0b required %h ir=0 ov=1",
                         i, now, in_ready, out_valid, got);
            else n_pass++;
        end
        in_valid = 1'b0;
        release_out();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL hold_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        else n_pass++;
        exp = sb.pop_front();
        n_total++;
        if (got !== exp) $display("FAIL hold_result: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   lat;
        res_t got, exp;
        drive(32'h00090000, 32'h00030000, 32'hFFFD0000, 32'h00030000, 1'b0);
        repeat (70) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if ({out0, out1, out2, out_valid, in_ready} !== {96'h0, 1'b0, 1'b1})
            $display("FAIL reset_mid: out %h %h %h ov=%0b ir=%0b required 0 0 0 ov=0 ir=1",
                     out0, out1, out2, out_valid, in_ready);
        else n_pass++;
        drive(32'hFFFF8000, 32'h00100000, 32'h00000003, 32'h00008000, 1'b1);
        wait_out(lat, got);
        exp = sb.pop_front();
        n_total++;
        if (got !== exp) $display("FAIL reset_mid_next: got %h required %h", got, exp);
        else n_pass++;
        n_total++;
        if (lat !== 150) $display("FAIL reset_mid_latency: got %0d required 150", lat);
        else n_pass++;
        release_out();
    endtask

    task automatic test_back_to_back();
        int          lat;
        res_t        got, exp;
        logic [31:0] r0, r1, r2, rd;
        for (int k = 0; k < 6; k++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom >> (k * 3);
            case (k % 3)
                0:       rd = $urandom;
                1:       rd = $urandom_range(1, 32'h0001FFFF);
                default: rd = (k == 2) ? 32'h0 : {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'(k)};
            endcase
            drive(r0, r1, r2, rd, 1'b1);
            wait_out(lat, got);
            exp = sb.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL b2b_%0d_result: got %h required %h (x=%h %h %h a=%h)",
                                      k, got, exp, r0, r1, r2, rd);
            else n_pass++;
            n_total++;
            if (lat !== 150) $display("FAIL b2b_%0d_latency: got %0d required 150", k, lat);
            else n_pass++;
            release_out();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x0 = '0; x1 = '0; x2 = '0; a = '0;
        test_reset();
        test_basic();
        test_div0();
        test_saturate();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
